// File: rtl/muldiv_unit_pkg.sv
// Shared ALU control codes and multiply/divide
// sequencer state encoding.
package muldiv_unit_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_DIV = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// start/busy/done handshake and result bus between
// the datapath and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic             div_by_zero;

  modport master (
    output start, alu_control, src_a, src_b,
    input  busy, done, lo, hi, div_by_zero
  );

  modport slave (
    input  start, alu_control, src_a, src_b,
    output busy, done, lo, hi, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed multiply / restoring divide,
// one bit per cycle on magnitudes, sign fixed at end.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               div_q, div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               dbz_q, dbz_d;

  logic               is_mul, is_div, accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     madd, shl, trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_mul = bus.alu_control == ALU_MUL;
  assign is_div = bus.alu_control == ALU_DIV;
  assign accept = bus.start && (is_mul || is_div);

  assign a_mag = bus.src_a[WIDTH-1] ? -bus.src_a
                                    : bus.src_a;
  assign b_mag = bus.src_b[WIDTH-1] ? -bus.src_b
                                    : bus.src_b;

  // mul: work_q = {partial product, multiplier}
  assign madd = {1'b0, work_q[2*WIDTH-1:WIDTH]}
              + (work_q[0] ? {1'b0, b_q} : '0);

  // div: work_q[WIDTH-1:0] shifts dividend out, quotient in
  assign shl   = {rem_q[WIDTH-1:0], work_q[WIDTH-1]};
  assign trial = shl - {1'b0, b_q};

  assign prod_fix = (sa_q ^ sb_q) ? -work_q : work_q;
  assign quo_fix  = (sa_q ^ sb_q) ? -work_q[WIDTH-1:0]
                                  : work_q[WIDTH-1:0];
  assign rem_fix  = sa_q ? -rem_q[WIDTH-1:0]
                         : rem_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    b_d     = b_q;
    work_d  = work_q;
    rem_d   = rem_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          div_d  = is_div;
          sa_d   = bus.src_a[WIDTH-1];
          sb_d   = bus.src_b[WIDTH-1];
          b_d    = b_mag;
          work_d = {{WIDTH{1'b0}}, a_mag};
          rem_d  = '0;
          cnt_d  = CW'(WIDTH - 1);
          dbz_d  = 1'b0;
          state_d = RUN;
          if (is_div && bus.src_b == '0) begin
            lo_d    = '1;
            hi_d    = bus.src_a;
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (div_q) begin
          rem_d = trial[WIDTH] ? shl : trial;
          work_d[WIDTH-1:0] = {work_q[WIDTH-2:0],
                               ~trial[WIDTH]};
        end else begin
          work_d = {madd, work_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        if (div_q) begin
          lo_d = quo_fix;
          hi_d = rem_fix;
        end else begin
          lo_d = prod_fix[WIDTH-1:0];
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      b_q     <= '0;
      work_q  <= '0;
      rem_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      b_q     <= b_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = state_q != IDLE;
  assign bus.done        = state_q == DONE;
  assign bus.lo          = lo_q;
  assign bus.hi          = hi_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit with
// hand-computed results and latency checks.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp_lo,
                        input logic [31:0] exp_hi,
                        input logic exp_dbz,
                        input int exp_lat,
                        input int inj_cyc);
    int cyc;
    int bcnt;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc  = 1;
    bcnt = 0;
    while (1) begin
      if (bus.busy) bcnt++;
      if (bus.done || cyc >= 200) break;
      if (cyc == inj_cyc) begin
        bus.start       = 1'b1;
        bus.alu_control = ALU_DIV;
        bus.src_a       = 32'd1;
        bus.src_b       = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk({tag, ".lat"}, 32'(cyc), 32'(exp_lat));
    chk({tag, ".busy"}, 32'(bcnt), 32'(exp_lat));
    chk({tag, ".lo"}, bus.lo, exp_lo);
    chk({tag, ".hi"}, bus.hi, exp_hi);
    chk({tag, ".dbz"}, 32'(bus.div_by_zero),
        32'(exp_dbz));
    @(posedge clk);
    #1;
    chk({tag, ".after"},
        32'({bus.done, bus.busy}), 32'd0);
    chk({tag, ".hold"}, bus.lo, exp_lo);
  endtask

  initial begin
    int dcnt;
    checks          = 0;
    failures        = 0;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.alu_control = ALU_ADD;
    bus.src_a       = '0;
    bus.src_b       = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ctl", 32'({bus.busy, bus.done,
        bus.div_by_zero}), 32'd0);
    chk("rst.lo", bus.lo, 32'd0);
    chk("rst.hi", bus.hi, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul7xm3", ALU_MUL, 32'd7, -32'sd3,
           32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 34, -1);
    run_op("mulmaxx2", ALU_MUL, 32'h7FFF_FFFF, 32'd2,
           32'hFFFF_FFFE, 32'h0, 1'b0, 34, -1);
    run_op("divm7d2", ALU_DIV, -32'sd7, 32'd2,
           32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, -1);
    run_op("div7dm2", ALU_DIV, 32'd7, -32'sd2,
           32'hFFFF_FFFD, 32'd1, 1'b0, 34, -1);
    run_op("div5d0", ALU_DIV, 32'd5, 32'd0,
           32'hFFFF_FFFF, 32'd5, 1'b1, 1, -1);
    run_op("mul2x3", ALU_MUL, 32'd2, 32'd3,
           32'd6, 32'd0, 1'b0, 34, -1);
    run_op("mulinj", ALU_MUL, 32'd12, 32'd10,
           32'd120, 32'd0, 1'b0, 34, 5);
    run_op("divovf", ALU_DIV, 32'h8000_0000,
           32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
           1'b0, 34, -1);

    // unsupported code in IDLE must be ignored
    @(negedge clk);
    bus.start       = 1'b1;
    bus.alu_control = ALU_ADD;
    bus.src_a       = 32'd9;
    bus.src_b       = 32'd9;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("add.busy", 32'(bus.busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("add.idle", 32'({bus.busy, bus.done}), 32'd0);
    chk("add.lo", bus.lo, 32'h8000_0000);

    // reset in the middle of a divide
    @(negedge clk);
    bus.start       = 1'b1;
    bus.alu_control = ALU_DIV;
    bus.src_a       = 32'd1000;
    bus.src_b       = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("rmid.busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rmid.ctl", 32'({bus.busy, bus.done,
        bus.div_by_zero}), 32'd0);
    chk("rmid.lo", bus.lo, 32'd0);
    chk("rmid.hi", bus.hi, 32'd0);
    dcnt = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done) dcnt++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.done) dcnt++;
    end
    chk("rmid.nodone", 32'(dcnt), 32'd0);
    run_op("div100d7", ALU_DIV, 32'd100, 32'd7,
           32'd14, 32'd2, 1'b0, 34, -1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
